// File: rtl/vu_lane_memq.sv
// rtl/vu_lane_memq.sv - lane memory-side queues; `VU_MEMQ_BYPASS_EN enables empty-queue bypass on vsdq/vldq
module vu_lane_memq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wptr_d = push_i ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = pop_i ? rptr_q + PTR_W'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage carries no reset; an empty queue masks its head to zero instead.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign count_o = cnt_q;
    assign rdata_o = (cnt_q == '0) ? '0 : mem_q[rptr_q];
endmodule

module vu_lane_memq #(
    parameter int DATA_W = 65,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsdq_val,
    input  logic [DATA_W-1:0] vsdq_bits,
    output logic              vsdq_deq_val,
    input  logic              vsdq_deq_rdy,
    output logic [DATA_W-1:0] vsdq_deq_bits,
    output logic [CNT_W-1:0]  vsdq_space,
    input  logic              vldq_enq_val,
    output logic              vldq_enq_rdy,
    input  logic [DATA_W-1:0] vldq_enq_bits,
    input  logic              vldq_rdy,
    output logic [DATA_W-1:0] vldq_bits,
    output logic [CNT_W-1:0]  vldq_count,
    input  logic              utaq_val,
    input  logic [ADDR_W-1:0] utaq_bits,
    input  logic              ut_op_store,
    input  logic              utsdq_val,
    input  logic [DATA_W-1:0] utsdq_bits,
    output logic [CNT_W-1:0]  utaq_space,
    output logic [CNT_W-1:0]  utsdq_space,
    output logic              ut_req_val,
    input  logic              ut_req_rdy,
    output logic              ut_req_store,
    output logic [ADDR_W-1:0] ut_req_addr,
    output logic [DATA_W-1:0] ut_req_data,
    input  logic              ut_resp_val,
    input  logic [DATA_W-1:0] ut_resp_bits,
    input  logic              utldq_rdy,
    output logic [DATA_W-1:0] utldq_bits,
    output logic [CNT_W-1:0]  utldq_space,
    output logic              err
);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   FULL_X = (CNT_W+1)'(DEPTH);

    logic [CNT_W-1:0]  vsdq_cnt, vldq_cnt, utaq_cnt, utsdq_cnt, utldq_cnt;
    logic [DATA_W-1:0] vsdq_head, vldq_head, utsdq_head;
    logic [ADDR_W:0]   utaq_head;
    logic              vsdq_push, vsdq_pop, vldq_push, vldq_pop;
    logic              utaq_push, utaq_pop, utsdq_push, utsdq_pop, utldq_push, utldq_pop;
    logic              vsdq_byp, vldq_byp, req_fire, head_op;
    logic              ld_inc, rsp_dec, overflow, underflow;
    logic [CNT_W-1:0]  out_q, out_d;
    logic              err_q, err_d;
    logic [CNT_W:0]    utldq_used;

    wire vsdq_full   = (vsdq_cnt == FULL);
    wire vsdq_empty  = (vsdq_cnt == '0);
    wire vldq_full   = (vldq_cnt == FULL);
    wire vldq_empty  = (vldq_cnt == '0);
    wire utaq_full   = (utaq_cnt == FULL);
    wire utaq_empty  = (utaq_cnt == '0);
    wire utsdq_full  = (utsdq_cnt == FULL);
    wire utsdq_empty = (utsdq_cnt == '0);
    wire utldq_full  = (utldq_cnt == FULL);
    wire utldq_empty = (utldq_cnt == '0);

`ifdef VU_MEMQ_BYPASS_EN
    assign vsdq_byp = vsdq_empty & vsdq_val;
    assign vldq_byp = vldq_empty & vldq_enq_val;
`else
    assign vsdq_byp = 1'b0;
    assign vldq_byp = 1'b0;
`endif

    // Lane-driven pushes never write into a full queue, even alongside a pop.
    assign vsdq_push     = vsdq_val & ~vsdq_full & ~(vsdq_byp & vsdq_deq_rdy);
    assign vsdq_pop      = ~vsdq_empty & vsdq_deq_rdy;
    assign vsdq_deq_val  = ~vsdq_empty | vsdq_byp;
    assign vsdq_deq_bits = vsdq_byp ? vsdq_bits : vsdq_head;
    assign vsdq_space    = FULL - vsdq_cnt;

    assign vldq_enq_rdy  = ~vldq_full;
    assign vldq_push     = vldq_enq_val & vldq_enq_rdy & ~(vldq_byp & vldq_rdy);
    assign vldq_pop      = vldq_rdy & ~vldq_empty;
    assign vldq_bits     = vldq_byp ? vldq_enq_bits : vldq_head;
    assign vldq_count    = vldq_cnt;

    assign head_op       = utaq_head[ADDR_W];
    assign ut_req_val    = ~utaq_empty & (~head_op | ~utsdq_empty);
    assign ut_req_store  = head_op;
    assign ut_req_addr   = utaq_head[ADDR_W-1:0];
    assign ut_req_data   = head_op ? utsdq_head : '0;
    assign req_fire      = ut_req_val & ut_req_rdy;
    assign utaq_push     = utaq_val & ~utaq_full;
    assign utaq_pop      = req_fire;
    assign utsdq_push    = utsdq_val & ~utsdq_full;
    assign utsdq_pop     = req_fire & head_op;
    assign utaq_space    = FULL - utaq_cnt;
    assign utsdq_space   = FULL - utsdq_cnt;

    assign utldq_push    = ut_resp_val & ~utldq_full;
    assign utldq_pop     = utldq_rdy & ~utldq_empty;
    assign utldq_used    = {1'b0, utldq_cnt} + {1'b0, out_q};
    assign utldq_space   = (utldq_used >= FULL_X) ? '0 : FULL - utldq_used[CNT_W-1:0];

    assign ld_inc    = req_fire & ~head_op;
    assign rsp_dec   = ut_resp_val & (out_q != '0);
    assign overflow  = (vsdq_val & vsdq_full) | (utaq_val & utaq_full) |
                       (utsdq_val & utsdq_full) | (ut_resp_val & utldq_full);
    assign underflow = (vldq_rdy & vldq_empty & ~vldq_byp) | (utldq_rdy & utldq_empty);

    always_comb begin
        out_d = out_q;
        if (ld_inc && !rsp_dec) begin
            out_d = out_q + CNT_W'(1);
        end else if (!ld_inc && rsp_dec) begin
            out_d = out_q - CNT_W'(1);
        end
        err_d = err_q | overflow | underflow | (ut_resp_val & (out_q == '0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

    vu_lane_memq_fifo #(.W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_vsdq (
        .clk(clk), .reset(reset), .push_i(vsdq_push), .wdata_i(vsdq_bits),
        .pop_i(vsdq_pop), .rdata_o(vsdq_head), .count_o(vsdq_cnt));

    vu_lane_memq_fifo #(.W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_vldq (
        .clk(clk), .reset(reset), .push_i(vldq_push), .wdata_i(vldq_enq_bits),
        .pop_i(vldq_pop), .rdata_o(vldq_head), .count_o(vldq_cnt));

    vu_lane_memq_fifo #(.W(ADDR_W+1), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_utaq (
        .clk(clk), .reset(reset), .push_i(utaq_push), .wdata_i({ut_op_store, utaq_bits}),
        .pop_i(utaq_pop), .rdata_o(utaq_head), .count_o(utaq_cnt));

    vu_lane_memq_fifo #(.W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_utsdq (
        .clk(clk), .reset(reset), .push_i(utsdq_push), .wdata_i(utsdq_bits),
        .pop_i(utsdq_pop), .rdata_o(utsdq_head), .count_o(utsdq_cnt));

    vu_lane_memq_fifo #(.W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_utldq (
        .clk(clk), .reset(reset), .push_i(utldq_push), .wdata_i(ut_resp_bits),
        .pop_i(utldq_pop), .rdata_o(utldq_bits), .count_o(utldq_cnt));
endmodule
